// File: rtl/apb2axi_fifo_wr_arb.sv
// Round-robin, burst-locked arbiter sharing one async-FIFO write port among NUM_REQ requesters.
// Each forwarded entry carries {src_id, payload}; forwarding is combinational, arbitration state is registered.
module apb2axi_fifo_wr_arb #(
  parameter int WIDTH     = 32,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                     wr_clk,
  input  logic                     wr_resetn,
  input  logic [NUM_REQ-1:0]       req_vld,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_rdy,
  output logic                     fifo_wr_vld,
  output logic [ID_W+WIDTH-1:0]    fifo_wr_data,
  input  logic                     fifo_wr_rdy,
  output logic                     burst_err
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {ST_ARB, ST_BURST} state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_owner;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic              r_burst_err;

  logic [WIDTH-1:0]  w_lane [NUM_REQ];
  logic              w_arb_found;
  logic [ID_W-1:0]   w_arb_idx;
  logic [ID_W:0]     w_cand;
  logic              w_gnt_vld;
  logic [ID_W-1:0]   w_gnt;
  logic              w_xfer;
  logic              w_last;
  logic              w_max_hit;

  // Explicit wrap so non-power-of-2 NUM_REQ never lands on an unused ID
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign w_lane[gi]  = req_data[gi*WIDTH +: WIDTH];
      assign req_rdy[gi] = w_gnt_vld & fifo_wr_rdy & (w_gnt == ID_W'(gi));
    end
  endgenerate

  // First valid requester at or after r_rr_ptr, modulo NUM_REQ
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    w_cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_cand >= (ID_W+1)'(NUM_REQ)) begin
        w_cand = w_cand - (ID_W+1)'(NUM_REQ);
      end
      if (!w_arb_found && req_vld[w_cand[ID_W-1:0]]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = w_cand[ID_W-1:0];
      end
    end
  end

  // A locked owner keeps the grant even while its valid is low
  assign w_gnt_vld    = (r_state == ST_BURST) | w_arb_found;
  assign w_gnt        = (r_state == ST_BURST) ? r_owner : w_arb_idx;
  assign fifo_wr_vld  = w_gnt_vld & req_vld[w_gnt];
  assign fifo_wr_data = w_gnt_vld ? {w_gnt, w_lane[w_gnt]} : '0;
  assign w_xfer       = fifo_wr_vld & fifo_wr_rdy;
  assign w_last       = req_last[w_gnt];
  assign w_max_hit    = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
  assign burst_err    = r_burst_err;

  always_ff @(posedge wr_clk or negedge wr_resetn) begin
    if (!wr_resetn) begin
      r_state     <= ST_ARB;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_beat_cnt  <= '0;
      r_burst_err <= 1'b0;
    end else if (w_xfer) begin
      case (r_state)
        ST_ARB: begin
          // With MAX_BURST=1 a non-last beat is already a forced release
          if (w_last || (MAX_BURST == 1)) begin
            r_rr_ptr <= next_id(w_gnt);
            if (!w_last) begin
              r_burst_err <= 1'b1;
            end
          end else begin
            r_state    <= ST_BURST;
            r_owner    <= w_gnt;
            r_beat_cnt <= CNT_W'(1);
          end
        end
        ST_BURST: begin
          if (w_last || w_max_hit) begin
            r_state    <= ST_ARB;
            r_rr_ptr   <= next_id(r_owner);
            r_beat_cnt <= '0;
            if (!w_last) begin
              r_burst_err <= 1'b1;
            end
          end else begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_apb2axi_fifo_wr_arb.sv
// Bench for apb2axi_fifo_wr_arb: directed scenarios plus random traffic against a
// behavioural arbitration model (lock flag, owner, round-robin pointer, beat count).
module tb_apb2axi_fifo_wr_arb;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int MAXB  = 4;
  localparam int IDW   = 2;

  logic                  wr_clk = 1'b0;
  logic                  wr_resetn = 1'b0;
  logic [NREQ-1:0]       req_vld = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       req_last = '0;
  logic [NREQ-1:0]       req_rdy;
  logic                  fifo_wr_vld;
  logic [IDW+WIDTH-1:0]  fifo_wr_data;
  logic                  fifo_wr_rdy = 1'b0;
  logic                  burst_err;

  apb2axi_fifo_wr_arb #(.WIDTH(WIDTH), .NUM_REQ(NREQ), .MAX_BURST(MAXB)) dut (
    .wr_clk       (wr_clk),
    .wr_resetn    (wr_resetn),
    .req_vld      (req_vld),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_rdy      (req_rdy),
    .fifo_wr_vld  (fifo_wr_vld),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_rdy  (fifo_wr_rdy),
    .burst_err    (burst_err)
  );

  always #5 wr_clk = ~wr_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit m_locked;
  int m_owner;
  int m_ptr;
  int m_beats;
  bit m_err;

  bit last_xfer;
  int last_id;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = 0;
    m_beats  = 0;
    m_err    = 1'b0;
  endtask

  task automatic model_grant(output bit has, output int g);
    has = 1'b0;
    g   = 0;
    if (m_locked) begin
      has = 1'b1;
      g   = m_owner;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (!has && req_vld[(m_ptr + k) % NREQ]) begin
          has = 1'b1;
          g   = (m_ptr + k) % NREQ;
        end
      end
    end
  endtask

  task automatic model_update(input int g);
    if (!m_locked) begin
      if (req_last[g]) begin
        m_ptr = (g + 1) % NREQ;
      end else if (MAXB == 1) begin
        m_ptr = (g + 1) % NREQ;
        m_err = 1'b1;
      end else begin
        m_locked = 1'b1;
        m_owner  = g;
        m_beats  = 1;
      end
    end else begin
      if (req_last[g]) begin
        m_locked = 1'b0;
        m_ptr    = (m_owner + 1) % NREQ;
        m_beats  = 0;
      end else if (m_beats + 1 == MAXB) begin
        m_locked = 1'b0;
        m_ptr    = (m_owner + 1) % NREQ;
        m_beats  = 0;
        m_err    = 1'b1;
      end else begin
        m_beats++;
      end
    end
  endtask

  task automatic check_outputs(input string tag, output bit xfer, output int g);
    bit              has;
    logic [NREQ-1:0] exp_rdy;
    logic [IDW-1:0]  gid;
    model_grant(has, g);
    gid     = g[IDW-1:0];
    xfer    = has && req_vld[g] && fifo_wr_rdy;
    exp_rdy = (has && fifo_wr_rdy) ? NREQ'(1 << g) : '0;
    chk_val({tag, "_vld"}, 64'(fifo_wr_vld), 64'(has && req_vld[g]));
    chk_val({tag, "_rdy"}, 64'(req_rdy), 64'(exp_rdy));
    if (has && req_vld[g]) begin
      chk_val({tag, "_data"}, 64'(fifo_wr_data), 64'({gid, req_data[g*WIDTH +: WIDTH]}));
    end
    chk_val({tag, "_err"}, 64'(burst_err), 64'(m_err));
  endtask

  task automatic step(input string tag, input logic [NREQ-1:0] vld, input logic [NREQ-1:0] last,
                      input logic rdy);
    bit x;
    int g;
    @(negedge wr_clk);
    req_vld     = vld;
    req_last    = last;
    fifo_wr_rdy = rdy;
    req_data    = {$urandom(), $urandom(), $urandom(), $urandom()};
    #1;
    check_outputs(tag, x, g);
    last_xfer = x;
    last_id   = x ? int'(fifo_wr_data[IDW+WIDTH-1:WIDTH]) : -1;
    if (x) $display("%s: xfer src=%0d data=%08h err=%0b", tag, g, fifo_wr_data[WIDTH-1:0], burst_err);
    @(posedge wr_clk);
    if (x) model_update(g);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit x;
    int g;
    logic [NREQ-1:0] rl;
    model_reset();
    repeat (2) @(negedge wr_clk);
    #1;
    check_outputs("reset", x, g);
    @(negedge wr_clk);
    wr_resetn = 1'b1;

    // 1: all valid, all last -> strict rotation
    for (int k = 0; k < 5; k++) begin
      step("t1", 4'b1111, 4'b1111, 1'b1);
      chk_val("t1_id", 64'(last_id), 64'(k % NREQ));
    end

    // 2: req1 three-beat burst, then req2
    step("t2", 4'b0111, 4'b0101, 1'b1); chk_val("t2_id_b1", 64'(last_id), 64'd1);
    step("t2", 4'b0111, 4'b0101, 1'b1); chk_val("t2_id_b2", 64'(last_id), 64'd1);
    step("t2", 4'b0111, 4'b0111, 1'b1); chk_val("t2_id_b3", 64'(last_id), 64'd1);
    step("t2", 4'b0111, 4'b0111, 1'b1); chk_val("t2_id_next", 64'(last_id), 64'd2);

    // 3: FIFO full mid-burst of req3
    step("t3", 4'b1000, 4'b0000, 1'b1); chk_val("t3_id_b1", 64'(last_id), 64'd3);
    for (int k = 0; k < 5; k++) begin
      step("t3_stall", 4'b1111, 4'b0000, 1'b0);
      chk_val("t3_rdy_zero", 64'(req_rdy), 64'd0);
    end
    step("t3", 4'b1111, 4'b0000, 1'b1); chk_val("t3_id_b2", 64'(last_id), 64'd3);
    step("t3", 4'b1111, 4'b1000, 1'b1); chk_val("t3_id_b3", 64'(last_id), 64'd3);
    step("t3", 4'b1111, 4'b1111, 1'b1); chk_val("t3_id_next", 64'(last_id), 64'd0);

    // 4: req2 pushes MAX_BURST beats without last -> forced release, sticky error
    for (int k = 0; k < MAXB; k++) begin
      step("t4", (k == 0) ? 4'b0100 : 4'b1110, 4'b0000, 1'b1);
      chk_val("t4_id", 64'(last_id), 64'd2);
    end
    step("t4", 4'b1001, 4'b1111, 1'b1);
    chk_val("t4_id_next", 64'(last_id), 64'd3);
    chk_val("t4_err", 64'(burst_err), 64'd1);

    // 5: locked owner req0 idles while req1 waits
    step("t5", 4'b0011, 4'b0000, 1'b1); chk_val("t5_id_b1", 64'(last_id), 64'd0);
    for (int k = 0; k < 2; k++) begin
      step("t5_idle", 4'b0010, 4'b0000, 1'b1);
      chk_val("t5_vld_low", 64'(fifo_wr_vld), 64'd0);
      chk_val("t5_rdy1_low", 64'(req_rdy[1]), 64'd0);
    end
    step("t5", 4'b0011, 4'b0001, 1'b1); chk_val("t5_id_b2", 64'(last_id), 64'd0);
    step("t5", 4'b0011, 4'b0011, 1'b1); chk_val("t5_id_next", 64'(last_id), 64'd1);

    // 6: reset in the middle of a req2 burst
    step("t6", 4'b0100, 4'b0000, 1'b1); chk_val("t6_id_b1", 64'(last_id), 64'd2);
    @(negedge wr_clk);
    wr_resetn   = 1'b0;
    req_vld     = 4'b1111;
    req_last    = 4'b0000;
    fifo_wr_rdy = 1'b1;
    #1;
    model_reset();
    check_outputs("t6_rst", x, g);
    chk_val("t6_rst_id", 64'(fifo_wr_data[IDW+WIDTH-1:WIDTH]), 64'd0);
    @(negedge wr_clk);
    wr_resetn = 1'b1;
    step("t6", 4'b0011, 4'b0011, 1'b1); chk_val("t6_tie_id", 64'(last_id), 64'd0);

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      for (int r = 0; r < NREQ; r++) rl[r] = ($urandom_range(0, 2) == 0);
      step("rnd", NREQ'($urandom_range(0, 15)), rl, ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
